fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader_pkg.sv | 15 +
 rtl/fifo_reader_buf.sv | 43 ++++
 rtl/fifo_stream_reader.sv | 76 +++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the sync_fifo stream reader.
package fifo_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BUF_DEPTH  = 4;

  // One-hot codes for the two protocol error kinds.
  localparam logic [1:0] ERR_UNSOLICITED = 2'b01;
  localparam logic [1:0] ERR_MISSING     = 2'b10;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Circular word buffer with read/write pointers and occupancy count.
module fifo_reader_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_BUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [DATA_WIDTH-1:0]     head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr) - CNT_W'(rd);
    end
  end

  // Storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a sync_fifo and re-presents the words as a valid/ready stream.
// Define FIFO_STREAM_READER_ERR_EN to build the sticky protocol checker on err_o.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          fifo_empty_i,
  output logic                          fifo_rd_en_o,
  input  logic                          fifo_rd_data_vaild_i,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data_i,
  output logic                          m_valid_o,
  output logic [DATA_WIDTH-1:0]         m_data_o,
  input  logic                          m_ready_i,
  output logic [cnt_w(BUF_DEPTH)-1:0]   buf_cnt_o,
  output logic                          err_o
);

  localparam int CNT_W = cnt_w(BUF_DEPTH);

  logic                  inflight;
  logic                  capture;
  logic                  pop;
  logic [CNT_W:0]        occupancy;
  logic [CNT_W-1:0]      buf_cnt;
  logic [DATA_WIDTH-1:0] head_data;

  // A slot is reserved for every in-flight word, so the buffer cannot overflow.
  assign occupancy    = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, inflight};
  assign fifo_rd_en_o = ~rst_n & enable_i & ~fifo_empty_i
                        & (occupancy < (CNT_W+1)'(BUF_DEPTH));

  // Words arriving with nothing in flight are discarded.
  assign capture   = fifo_rd_data_vaild_i & inflight;
  assign m_valid_o = (buf_cnt != '0);
  assign pop       = m_valid_o & m_ready_i;
  assign m_data_o  = m_valid_o ? head_data : '0;
  assign buf_cnt_o = buf_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) inflight <= 1'b0;
    else       inflight <= fifo_rd_en_o;
  end

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (capture),
    .wr_data   (fifo_rd_data_i),
    .rd        (pop),
    .count     (buf_cnt),
    .head_data (head_data)
  );

`ifdef FIFO_STREAM_READER_ERR_EN
  logic [1:0] err_kind;

  assign err_kind = ({2{fifo_rd_data_vaild_i & ~inflight}} & ERR_UNSOLICITED)
                  | ({2{~fifo_rd_data_vaild_i & inflight}} & ERR_MISSING);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)          err_o <= 1'b0;
    else if (|err_kind) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised and directed bench for fifo_stream_reader against a queue-based model.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int DW = 32;
  localparam int BD = 4;
  localparam int CW = cnt_w(BD);
`ifdef FIFO_STREAM_READER_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          enable_i;
  logic          fifo_empty_i;
  logic          fifo_rd_en_o;
  logic          fifo_rd_data_vaild_i;
  logic [DW-1:0] fifo_rd_data_i;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i;
  logic [CW-1:0] buf_cnt_o;
  logic          err_o;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable_i             (enable_i),
    .fifo_empty_i         (fifo_empty_i),
    .fifo_rd_en_o         (fifo_rd_en_o),
    .fifo_rd_data_vaild_i (fifo_rd_data_vaild_i),
    .fifo_rd_data_i       (fifo_rd_data_i),
    .m_valid_o            (m_valid_o),
    .m_data_o             (m_data_o),
    .m_ready_i            (m_ready_i),
    .buf_cnt_o            (buf_cnt_o),
    .err_o                (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Upstream FIFO contents, words held by the reader, and words delivered.
  logic [31:0] up_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] out_log[$];
  logic [31:0] sent[$];
  bit          m_inflight, ret_v, inj_v, err_exp;
  logic [31:0] ret_d, inj_d;
  int          cyc, rd_pulses, first_rd, last_rd, first_val;

  task automatic clr();
    rd_pulses = 0;
    first_rd  = -1;
    last_rd   = -1;
    first_val = -1;
    out_log.delete();
  endtask

  task automatic cycle(input bit en, input bit rdy);
    bit          rd_s, pop_s, cap_s, v_s, exp_rd;
    logic [1:0]  kind;
    logic [31:0] d_s;
    @(negedge clk);
    enable_i             = en;
    m_ready_i            = rdy;
    fifo_empty_i         = (up_q.size() == 0);
    fifo_rd_data_vaild_i = ret_v | inj_v;
    fifo_rd_data_i       = inj_v ? inj_d : ret_d;
    #1;
    exp_rd = en && (up_q.size() != 0) && (exp_q.size() + int'(m_inflight) < BD);
    chk("rd_en", fifo_rd_en_o, exp_rd);
    chk("m_valid", m_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("m_data", m_data_o, exp_q[0]);
    chk("buf_cnt", buf_cnt_o, exp_q.size());
    chk("err", err_o, err_exp);
    rd_s  = fifo_rd_en_o;
    v_s   = fifo_rd_data_vaild_i;
    d_s   = fifo_rd_data_i;
    pop_s = (exp_q.size() != 0) && rdy;
    cap_s = v_s && m_inflight;
    kind  = ((v_s && !m_inflight) ? ERR_UNSOLICITED : 2'b00)
          | ((!v_s && m_inflight) ? ERR_MISSING : 2'b00);
    if (rd_s) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (exp_q.size() != 0 && first_val < 0) first_val = cyc;
    @(posedge clk);
    if (pop_s) out_log.push_back(exp_q.pop_front());
    if (cap_s) exp_q.push_back(d_s);
    if (ERR_ON && kind != 2'b00) err_exp = 1'b1;
    m_inflight = rd_s;
    ret_v      = rd_s;
    if (rd_s && up_q.size() != 0) ret_d = up_q.pop_front();
    inj_v = 1'b0;
    cyc++;
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_rd_en", fifo_rd_en_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_buf_cnt", buf_cnt_o, 0);
    chk("rst_err", err_o, 0);
    enable_i             = 1'b0;
    fifo_empty_i         = 1'b1;
    fifo_rd_data_vaild_i = 1'b0;
    up_q.delete();
    exp_q.delete();
    m_inflight = 0;
    ret_v      = 0;
    inj_v      = 0;
    err_exp    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit found;
    rst_n = 1'b1;
    enable_i = 0; fifo_empty_i = 1; fifo_rd_data_vaild_i = 0;
    fifo_rd_data_i = '0; m_ready_i = 0;
    ret_d = '0; inj_d = '0; cyc = 0;
    do_reset();

    // Three words streamed straight through.
    clr();
    up_q = '{32'd5, 32'd6, 32'd7};
    repeat (8) cycle(1, 1);
    chk("t1_rd_pulses", rd_pulses, 3);
    chk("t1_rd_consecutive", last_rd - first_rd, 2);
    chk("t1_fill_latency", first_val - first_rd, 2);
    chk("t1_out_n", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) chk("t1_out", out_log[i], 5 + i);

    // Back-pressure fills the buffer, then eight words drain back to back.
    clr();
    for (int i = 10; i < 18; i++) up_q.push_back(i);
    repeat (8) cycle(1, 0);
    chk("t2_rd_pulses", rd_pulses, 4);
    #1;
    chk("t2_buf_full", buf_cnt_o, 4);
    chk("t2_head", m_data_o, 10);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 1);
      n++;
      if (out_log.size() >= 8) break;
    end
    chk("t2_drain_cycles", n, 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("t2_out", out_log[i], 10 + i);

    // Empty upstream, then a single word arrives.
    clr();
    repeat (4) cycle(1, 1);
    chk("t3_idle_rd", rd_pulses, 0);
    up_q.push_back(32'd23);
    repeat (5) cycle(1, 1);
    chk("t3_rd_pulses", rd_pulses, 1);
    chk("t3_out_n", out_log.size(), 1);
    if (out_log.size() > 0) chk("t3_out", out_log[0], 23);

    // Enable drops right after issuing the read for 45.
    clr();
    up_q = '{32'd45, 32'd46};
    cycle(1, 1);
    repeat (5) cycle(0, 1);
    chk("t4_rd_pulses", rd_pulses, 1);
    chk("t4_out_n", out_log.size(), 1);
    if (out_log.size() > 0) chk("t4_out", out_log[0], 45);
    chk("t4_fifo_left", up_q.size(), 1);
    up_q.delete();
    cycle(0, 1);

    // Unsolicited word is dropped and flagged when the checker is built.
    clr();
    inj_v = 1'b1;
    inj_d = 32'd99;
    repeat (4) cycle(1, 1);
    #1;
    chk("t5_err_sticky", err_o, ERR_ON);
    found = 0;
    foreach (out_log[i]) if (out_log[i] == 32'd99) found = 1;
    chk("t5_no_99", found, 0);

    // Reset with three words buffered.
    clr();
    up_q = '{32'd1, 32'd2, 32'd3};
    for (int k = 0; k < 10 && exp_q.size() < 3; k++) cycle(1, 0);
    #1;
    chk("t6_pre_cnt", buf_cnt_o, 3);
    do_reset();

    // Random traffic, then a bounded drain and an end-to-end order check.
    clr();
    sent.delete();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [31:0] w;
        w = $urandom;
        up_q.push_back(w);
        sent.push_back(w);
      end
      cycle($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
    end
    found = 0;
    for (int k = 0; k < 300; k++) begin
      if (up_q.size() == 0 && exp_q.size() == 0 && !m_inflight) begin
        found = 1;
        break;
      end
      cycle(1, 1);
    end
    chk("t7_drained", found, 1);
    chk("t7_out_n", out_log.size(), sent.size());
    for (int i = 0; i < sent.size() && i < out_log.size(); i++) chk("t7_order", out_log[i], sent[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
